// File: rtl/riscv_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IBUSY,
        ARB_DBUSY
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants made while a fetch is waiting; saturates at MAX_DATA_BURST.
module arb_starve_ctr #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_DATA_BURST);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CMAX)) begin
            count <= count + CW'(1);
        end
    end

    assign at_max = (count == CMAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data requesters (data has priority).
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int XLEN = riscv_pkg::XLEN_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_DATA_BURST = 4
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IReqF,
    input  logic [XLEN-1:0] IAddrF,
    output logic [XLEN-1:0] IRdataF,
    output logic            IReadyF,
    input  logic            DReqM,
    input  logic            DWeM,
    input  logic [XLEN-1:0] DAddrM,
    input  logic [XLEN-1:0] DWdataM,
    input  logic [3:0]      DBeM,
    output logic [XLEN-1:0] DRdataM,
    output logic            DReadyM,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWdata,
    output logic [3:0]      MemBe,
    input  logic [XLEN-1:0] MemRdata,
    input  logic            MemAck,
    output logic            StallF,
    output logic            StallM
);

    import riscv_pkg::*;

    arb_state_t state;
    arb_state_t state_next;

    logic            lat_we;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [3:0]      lat_be;

    logic busy;
    logic i_done;
    logic d_done;
    logic force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic guard_inc;
    logic guard_clr;
    logic guard_full;

    assign guard_inc = (state == ARB_IDLE) && (state_next == ARB_DBUSY) && IReqF;
    assign guard_clr = (state == ARB_IDLE) && ((state_next == ARB_IBUSY) || !IReqF);

    arb_starve_ctr #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (guard_inc),
        .clr   (guard_clr),
        .at_max(guard_full)
    );

    assign force_fetch = guard_full && IReqF;
`else
    assign force_fetch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The memory sees only the latched request, so requester changes mid-access are invisible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (state == ARB_IDLE) begin
            if (state_next == ARB_DBUSY) begin
                lat_we    <= DWeM;
                lat_addr  <= DAddrM;
                lat_wdata <= DWdataM;
                lat_be    <= DWeM ? DBeM : BE_FULL;
            end else if (state_next == ARB_IBUSY) begin
                lat_we    <= 1'b0;
                lat_addr  <= IAddrF;
                lat_wdata <= '0;
                lat_be    <= BE_FULL;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (DReqM && !force_fetch) begin
                    state_next = ARB_DBUSY;
                end else if (IReqF) begin
                    state_next = ARB_IBUSY;
                end
            end
            ARB_IBUSY: begin
                busy = 1'b1;
                if (MemAck) begin
                    i_done     = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            ARB_DBUSY: begin
                busy = 1'b1;
                if (MemAck) begin
                    d_done     = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Every output is forced quiet while reset is held low, regardless of stored state.
    assign MemReq   = reset && busy;
    assign MemWe    = MemReq && lat_we;
    assign MemAddr  = reset ? lat_addr : '0;
    assign MemWdata = reset ? lat_wdata : '0;
    assign MemBe    = reset ? lat_be : '0;

    assign IReadyF  = reset && i_done;
    assign DReadyM  = reset && d_done;
    assign IRdataF  = IReadyF ? MemRdata : '0;
    assign DRdataM  = DReadyM ? MemRdata : '0;

    assign StallF   = reset && IReqF && !i_done;
    assign StallM   = reset && DReqM && !d_done;

endmodule
